branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
- Parametrised branch prediction unit for the 5-stage RISC-V pipeline; successor to the fixed single-entry predictor in the IF path.
- Direct-mapped branch target buffer (BTB) with per-entry saturating counters, looked up combinationally from the IF PC.
- Trained from EX-stage resolution. Produces a mispredict flag and a redirect PC that drive the pipeline flush and the PC mux.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 16, BTB entries; power of two, ≥2. IDX_W = log2(ENTRIES).
- CTR_W, 2, saturating counter width, 1..4. CTR_MAX = 2^CTR_W-1; TAKEN_TH = 2^(CTR_W-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_pc  in  XLEN  fetch PC
- pred_hit  out  1  valid tag match for if_pc
- pred_taken  out  1  hit && counter ≥ TAKEN_TH
- pred_target  out  XLEN  stored target; 0 when !pred_hit
- ex_valid  in  1  EX slot holds a real instruction
- ex_is_branch  in  1  EX instruction is branch/JAL
- ex_pc  in  XLEN  EX instruction PC
- ex_taken  in  1  resolved direction
- ex_target  in  XLEN  resolved target
- ex_pred_taken  in  1  prediction carried down the pipe
- ex_pred_target  in  XLEN  predicted target carried down the pipe
- mispredict  out  1  flush IF/ID
- redirect_pc  out  XLEN  correct next PC

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Field split:
  - index = pc[IDX_W+1:2]
  - tag = pc[XLEN-1:IDX_W+2]
  - pc[1:0] is ignored.
- Lookup: combinational, zero latency. Reads registered state only; there is no same-cycle bypass of an update.
- Reset:
  - All valid bits cleared; counters set to TAKEN_TH-1 (weakly not-taken).
  - While rst=1: pred_hit, pred_taken and mispredict are forced to 0; pred_target and redirect_pc are 0.
  - Reset asserted mid-training discards that cycle's update.
- mispredict is combinational and asserted when ex_valid and any of the following holds:
  - ex_is_branch && ex_taken != ex_pred_taken;
  - ex_is_branch && ex_taken && ex_pred_taken && ex_target != ex_pred_target;
  - !ex_is_branch && ex_pred_taken (aliasing false hit).
- redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc+4, with wrap modulo 2^XLEN. It is valid only when mispredict=1.
- Update, applied at the clk edge when ex_valid && !rst:
  - Branch taken, tag hit: target := ex_target; counter := min(ctr+1, CTR_MAX).
  - Branch taken, miss or invalid: allocate. Valid := 1, tag/target written, counter := TAKEN_TH (weakly taken). Any old entry at that index is overwritten.
  - Branch not taken, hit: counter := max(ctr-1, 0). The entry stays valid.
  - Branch not taken, miss: no change.
  - Non-branch that hits: valid := 0.
- Only one update per cycle. A simultaneous lookup of the same index sees the pre-update value.
- CTR_W=1 degenerates to last-outcome prediction (TAKEN_TH=1).

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - Adds a global history register ghr[IDX_W-1:0], reset 0.
  - On every ex_valid && ex_is_branch update, ghr := {ghr[IDX_W-2:0], ex_taken}.
  - The counter array is indexed by index ^ ghr, using the pre-shift ghr for both lookup and update in that cycle.
  - Tag, target and valid bits remain PC-indexed.
  - pred_taken = pred_hit && counter[index ^ ghr] ≥ TAKEN_TH.
- Undefined: no ghr; counters are PC-indexed exactly as described above.

Decomposition:
- Package bp_pkg holds:
  - idx/tag width functions;
  - sat_inc/sat_dec functions (parametrised by CTR_W);
  - the counter reset constant;
  - the PC increment constant 4.
- One sub-module, bp_btb_array: the tag/target/valid storage with one combinational read port, one synchronous write port, and an invalidate input.
- Counters and ghr live in the top level.

Test Plan (defaults: ENTRIES=16, CTR_W=2; 0x40 and 0x80 share index 0):
- Reset, then if_pc=0x40 → pred_hit=0, pred_taken=0, pred_target=0.
- EX branch at 0x40, taken, target 0x80, ex_pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x40 → pred_hit=1, pred_taken=1, pred_target=0x80 (counter=2).
- Four more taken resolutions at 0x40 → counter saturates at 3. Then two not-taken resolutions → counter=1, pred_hit=1, pred_taken=0.
- EX 0x40, ex_pred_taken=1, ex_pred_target=0x80, taken to 0x100 → mispredict=1, redirect 0x100, stored target becomes 0x100.
- EX 0x40 predicted taken, resolved not-taken → redirect_pc=0x44. Taken branch at 0x80 (same index, new tag) → lookup 0x40 gives pred_hit=0. Non-branch hit at 0x80 → entry invalidated.
- Train the entry, assert rst for one cycle with a concurrent update → all lookups miss, mispredict=0 during reset. With BP_GSHARE_EN, alternate T/N at 0x40 → ghr sequence 0x1, 0x2, 0x5.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants, saturating-counter helpers and update classification for the BTB predictor.
package bp_pkg;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [2:0] {
        UPD_NONE,
        UPD_TRAIN_T,
        UPD_ALLOC,
        UPD_TRAIN_N,
        UPD_INVAL
    } upd_e;

    function automatic int unsigned idx_width(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned tag_width(input int unsigned xlen, input int unsigned entries);
        return xlen - $clog2(entries) - 2;
    endfunction

    // Counters are at most 4 bits wide, so the helpers work on a 4-bit carrier.
    function automatic logic [3:0] ctr_max(input int unsigned ctr_w);
        return 4'((1 << ctr_w) - 1);
    endfunction

    function automatic logic [3:0] ctr_taken_th(input int unsigned ctr_w);
        return 4'(1 << (ctr_w - 1));
    endfunction

    function automatic logic [3:0] ctr_reset(input int unsigned ctr_w);
        return ctr_taken_th(ctr_w) - 4'd1;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] ctr, input int unsigned ctr_w);
        return (ctr >= ctr_max(ctr_w)) ? ctr_max(ctr_w) : ctr + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] ctr);
        return (ctr == 4'd0) ? 4'd0 : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/bp_btb_array.sv
// Tag/target/valid storage: one combinational read port, one synchronous write port
// with a tag-match probe at the write index, and an invalidate strobe.
module bp_btb_array
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [TAG_W-1:0] i_rd_tag,
    output logic             o_rd_hit,
    output logic [XLEN-1:0]  o_rd_target,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    output logic             o_wr_match,
    input  logic             i_wr_en,
    input  logic [XLEN-1:0]  i_wr_target,
    input  logic             i_inv_en
);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];

    assign o_rd_hit    = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_target = r_target[i_rd_idx];
    assign o_wr_match  = r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end else if (i_inv_en) begin
            r_valid[i_wr_idx] <= 1'b0;
        end
    end

    // Tag and target need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && i_wr_en) begin
            r_tag[i_wr_idx]    <= i_wr_tag;
            r_target[i_wr_idx] <= i_wr_target;
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB branch predictor with saturating counters, trained from EX.
// Optional gshare counter indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int IDX_W = idx_width(ENTRIES);
    localparam int TAG_W = tag_width(XLEN, ENTRIES);
    localparam logic [CTR_W-1:0] TAKEN_TH = CTR_W'(ctr_taken_th(CTR_W));
    localparam logic [CTR_W-1:0] CTR_RST  = CTR_W'(ctr_reset(CTR_W));

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic [IDX_W-1:0] w_if_cidx;
    logic [IDX_W-1:0] w_ex_cidx;
    logic             w_if_hit;
    logic [XLEN-1:0]  w_if_target;
    logic             w_ex_hit;
    logic             w_unused_pc_lsbs;
    logic [CTR_W-1:0] w_if_ctr;
    upd_e             w_upd;

    logic [CTR_W-1:0] r_ctr [ENTRIES];

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[XLEN-1:IDX_W+2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];
    assign w_unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    bp_btb_array #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (w_if_idx),
        .i_rd_tag    (w_if_tag),
        .o_rd_hit    (w_if_hit),
        .o_rd_target (w_if_target),
        .i_wr_idx    (w_ex_idx),
        .i_wr_tag    (w_ex_tag),
        .o_wr_match  (w_ex_hit),
        .i_wr_en     ((w_upd == UPD_TRAIN_T) || (w_upd == UPD_ALLOC)),
        .i_wr_target (ex_target),
        .i_inv_en    (w_upd == UPD_INVAL)
    );

    always_comb begin
        w_upd = UPD_NONE;
        if (ex_valid && !rst) begin
            if (ex_is_branch) begin
                if (ex_taken)
                    w_upd = w_ex_hit ? UPD_TRAIN_T : UPD_ALLOC;
                else if (w_ex_hit)
                    w_upd = UPD_TRAIN_N;
            end else if (w_ex_hit) begin
                w_upd = UPD_INVAL;
            end
        end
    end

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    // Lookup and update both use the history as it stood before this cycle's shift.
    always_ff @(posedge clk) begin
        if (rst)
            r_ghr <= '0;
        else if (ex_valid && ex_is_branch)
            r_ghr <= (r_ghr << 1) | IDX_W'(ex_taken);
    end

    assign w_if_cidx = w_if_idx ^ r_ghr;
    assign w_ex_cidx = w_ex_idx ^ r_ghr;
`else
    assign w_if_cidx = w_if_idx;
    assign w_ex_cidx = w_ex_idx;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                r_ctr[i] <= CTR_RST;
        end else begin
            case (w_upd)
                UPD_TRAIN_T: r_ctr[w_ex_cidx] <= CTR_W'(sat_inc(4'(r_ctr[w_ex_cidx]), CTR_W));
                UPD_ALLOC:   r_ctr[w_ex_cidx] <= TAKEN_TH;
                UPD_TRAIN_N: r_ctr[w_ex_cidx] <= CTR_W'(sat_dec(4'(r_ctr[w_ex_cidx])));
                default:     ;
            endcase
        end
    end

    assign w_if_ctr    = r_ctr[w_if_cidx];
    assign pred_hit    = !rst && w_if_hit;
    assign pred_taken  = pred_hit && (w_if_ctr >= TAKEN_TH);
    assign pred_target = pred_hit ? w_if_target : '0;

    // A predicted-taken non-branch means an aliased entry fired a false hit.
    assign mispredict = !rst && ex_valid &&
        ((ex_is_branch && ((ex_taken != ex_pred_taken) ||
                           (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)))) ||
         (!ex_is_branch && ex_pred_taken));

    assign redirect_pc = rst ? '0 :
        ((ex_is_branch && ex_taken) ? ex_target : ex_pc + XLEN'(PC_INC));

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed table, reset/history sequences,
// and randomized traffic against an array-based reference model (BP_GSHARE_EN aware).
module tb_branch_predictor_btb;

    localparam int NDIR = 22;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [31:0] if_pc;
        logic        exv;
        logic        exb;
        logic [31:0] expc;
        logic        ext;
        logic [31:0] ext_tgt;
        logic        ept;
        logic [31:0] ept_tgt;
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_tgt;
        logic        e_mis;
        logic [31:0] e_red;
    } vec_t;

    vec_t dir[NDIR];

    // Reference model state: plain arrays indexed by PC field, counters as integers.
    bit          m_valid[16];
    logic [31:0] m_tag[16];
    logic [31:0] m_tgt[16];
    int          m_ctr[16];
    int          m_ghr;

    branch_predictor_btb #(
        .XLEN    (32),
        .ENTRIES (16),
        .CTR_W   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [31:0] ipc,
                                input logic exv, input logic exb, input logic [31:0] expc,
                                input logic ext, input logic [31:0] ettgt,
                                input logic ept, input logic [31:0] eptgt,
                                input logic eh, input logic etk, input logic [31:0] etgt,
                                input logic emis, input logic [31:0] ered);
        vec_t v;
        v.rst = r; v.if_pc = ipc; v.exv = exv; v.exb = exb; v.expc = expc;
        v.ext = ext; v.ext_tgt = ettgt; v.ept = ept; v.ept_tgt = eptgt;
        v.e_hit = eh; v.e_taken = etk; v.e_tgt = etgt; v.e_mis = emis; v.e_red = ered;
        return v;
    endfunction

    function automatic int cidx_of(input int idx);
`ifdef BP_GSHARE_EN
        return idx ^ m_ghr;
`else
        return idx;
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_ghr = 0;
    endtask

    task automatic m_look(input logic [31:0] pc, output logic hit, output logic tk,
                          output logic [31:0] tgt);
        int idx;
        idx = int'((pc / 4) % 16);
        hit = m_valid[idx] && (m_tag[idx] == (pc / 64));
        tk  = hit && (m_ctr[cidx_of(idx)] >= 2);
        tgt = hit ? m_tgt[idx] : 32'h0;
    endtask

    task automatic m_update(input vec_t v);
        int idx, ci;
        bit hit;
        if (v.rst) begin
            m_reset();
            return;
        end
        if (!v.exv) return;
        idx = int'((v.expc / 4) % 16);
        ci  = cidx_of(idx);
        hit = m_valid[idx] && (m_tag[idx] == (v.expc / 64));
        if (v.exb) begin
            if (v.ext) begin
                if (hit) begin
                    m_tgt[idx] = v.ext_tgt;
                    m_ctr[ci]  = (m_ctr[ci] < 3) ? m_ctr[ci] + 1 : 3;
                end else begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = v.expc / 64;
                    m_tgt[idx]   = v.ext_tgt;
                    m_ctr[ci]    = 2;
                end
            end else if (hit) begin
                m_ctr[ci] = (m_ctr[ci] > 0) ? m_ctr[ci] - 1 : 0;
            end
            m_ghr = ((m_ghr * 2) + int'(v.ext)) % 16;
        end else if (hit) begin
            m_valid[idx] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check the combinational outputs before the edge,
    // then let the model follow the clock edge.
    task automatic apply(input vec_t v, input bit use_tbl);
        logic        hit, tk, mis;
        logic [31:0] tgt, red;
        @(negedge clk);
        rst = v.rst; if_pc = v.if_pc; ex_valid = v.exv; ex_is_branch = v.exb;
        ex_pc = v.expc; ex_taken = v.ext; ex_target = v.ext_tgt;
        ex_pred_taken = v.ept; ex_pred_target = v.ept_tgt;
        #1;
        if (v.rst) begin
            hit = 0; tk = 0; tgt = 0; mis = 0; red = 0;
        end else begin
            m_look(v.if_pc, hit, tk, tgt);
            mis = v.exv && ((v.exb && ((v.ext != v.ept) ||
                                       (v.ext && v.ept && (v.ext_tgt != v.ept_tgt)))) ||
                            (!v.exb && v.ept));
            red = (v.exb && v.ext) ? v.ext_tgt : v.expc + 32'd4;
        end
        chk("model_hit", 32'(pred_hit), 32'(hit));
        chk("model_taken", 32'(pred_taken), 32'(tk));
        chk("model_target", pred_target, tgt);
        chk("model_mispredict", 32'(mispredict), 32'(mis));
        if (mis || v.rst) chk("model_redirect", redirect_pc, red);
        if (use_tbl) begin
            chk("tbl_hit", 32'(pred_hit), 32'(v.e_hit));
`ifndef BP_GSHARE_EN
            chk("tbl_taken", 32'(pred_taken), 32'(v.e_taken));
`endif
            chk("tbl_target", pred_target, v.e_tgt);
            chk("tbl_mispredict", 32'(mispredict), 32'(v.e_mis));
            if (v.e_mis || v.rst) chk("tbl_redirect", redirect_pc, v.e_red);
        end
        @(posedge clk);
        m_update(v);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        if ($urandom_range(0, 19) == 0)
            pc = 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
        else
            pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
                 32'($urandom_range(0, 3));
        return pc;
    endfunction

    initial begin
        vec_t        v;
        logic        h, t;
        logic [31:0] g;

        dir[0]  = mk(1, 32'h40, 0, 0, 0,      0, 0,      0, 0,     0, 0, 0,      0, 0);
        dir[1]  = mk(0, 32'h40, 0, 0, 0,      0, 0,      0, 0,     0, 0, 0,      0, 0);
        dir[2]  = mk(0, 32'h40, 1, 1, 32'h40, 1, 32'h80, 0, 0,     0, 0, 0,      1, 32'h80);
        dir[3]  = mk(0, 32'h40, 1, 1, 32'h40, 1, 32'h80, 1, 32'h80, 1, 1, 32'h80, 0, 0);
        dir[4]  = dir[3];
        dir[5]  = dir[3];
        dir[6]  = dir[3];
        dir[7]  = mk(0, 32'h40, 1, 1, 32'h40, 0, 0,      1, 32'h80, 1, 1, 32'h80, 1, 32'h44);
        dir[8]  = dir[7];
        dir[9]  = mk(0, 32'h40, 0, 0, 0,      0, 0,      0, 0,     1, 0, 32'h80, 0, 0);
        dir[10] = mk(0, 32'h40, 1, 1, 32'h40, 1, 32'h100, 1, 32'h80, 1, 0, 32'h80, 1, 32'h100);
        dir[11] = mk(0, 32'h40, 0, 0, 0,      0, 0,      0, 0,     1, 1, 32'h100, 0, 0);
        dir[12] = mk(0, 32'h40, 1, 1, 32'h80, 1, 32'h200, 0, 0,    1, 1, 32'h100, 1, 32'h200);
        dir[13] = mk(0, 32'h40, 0, 0, 0,      0, 0,      0, 0,     0, 0, 0,      0, 0);
        dir[14] = mk(0, 32'h80, 1, 0, 32'h80, 0, 0,      1, 32'h200, 1, 1, 32'h200, 1, 32'h84);
        dir[15] = mk(0, 32'h80, 0, 0, 0,      0, 0,      0, 0,     0, 0, 0,      0, 0);
        dir[16] = mk(0, 32'h80, 1, 1, 32'h80, 1, 32'h200, 0, 0,    0, 0, 0,      1, 32'h200);
        dir[17] = mk(1, 32'h80, 1, 1, 32'h80, 1, 32'h300, 0, 0,    0, 0, 0,      0, 0);
        dir[18] = mk(0, 32'h80, 0, 0, 0,      0, 0,      0, 0,     0, 0, 0,      0, 0);
        dir[19] = mk(0, 32'h80, 1, 0, 32'hFFFF_FFFC, 0, 0, 1, 32'h123, 0, 0, 0, 1, 32'h0);
        dir[20] = mk(0, 32'h80, 0, 1, 32'h40, 1, 32'h80, 1, 32'h80, 0, 0, 0,     0, 0);
        dir[21] = mk(0, 32'h80, 1, 1, 32'h80, 0, 0,      0, 0,     0, 0, 0,      0, 0);

        rst = 1'b1; if_pc = 0; ex_valid = 0; ex_is_branch = 0; ex_pc = 0;
        ex_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
        m_reset();

        for (int i = 0; i < NDIR; i++) apply(dir[i], 1'b1);

        // Drive a counter down to zero: entry must stay valid and predict not-taken.
        apply(mk(0, 32'h40, 1, 1, 32'h40, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        for (int i = 0; i < 4; i++)
            apply(mk(0, 32'h40, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        @(negedge clk);
        rst = 0; if_pc = 32'h40; ex_valid = 0;
        #1;
        chk("floor_hit", 32'(pred_hit), 32'd1);
        chk("floor_taken", 32'(pred_taken), 32'd0);
        chk("floor_target", pred_target, 32'h80);

`ifdef BP_GSHARE_EN
        apply(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        apply(mk(0, 32'h40, 1, 1, 32'h40, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        #1 chk("ghr_1", 32'(dut.r_ghr), 32'h1);
        apply(mk(0, 32'h40, 1, 1, 32'h40, 0, 0, 1, 32'h80, 0, 0, 0, 0, 0), 1'b0);
        #1 chk("ghr_2", 32'(dut.r_ghr), 32'h2);
        apply(mk(0, 32'h40, 1, 1, 32'h40, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        #1 chk("ghr_5", 32'(dut.r_ghr), 32'h5);
`endif

        for (int n = 0; n < 1500; n++) begin
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.rst     = ($urandom_range(0, 99) == 0);
            v.if_pc   = rand_pc();
            v.exv     = ($urandom_range(0, 3) != 0);
            v.exb     = ($urandom_range(0, 4) != 0);
            v.expc    = rand_pc();
            v.ext     = 1'($urandom_range(0, 1));
            v.ext_tgt = 32'($urandom_range(1, 8)) << 4;
            if ($urandom_range(0, 9) < 7) begin
                m_look(v.expc, h, t, g);
                v.ept = t; v.ept_tgt = g;
            end else begin
                v.ept     = 1'($urandom_range(0, 1));
                v.ept_tgt = 32'($urandom_range(1, 8)) << 4;
            end
            apply(v, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
